// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, instruction
// fields, and the datapath select/ALU codes.
package multicycle_controller_pkg;

    // J and JAL share one state, as do MFHI and MFLO, so that all sixteen
    // states fit the 4-bit debug port. The per-instruction differences in
    // those states come from the opcode/func held in the instruction register.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_MULT     = 4'd13,
        S_MFHL     = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_MULT = 4'd8;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_SEXT    = 2'd2;
    localparam logic [1:0] SRCB_SEXT_SH = 2'd3;

    localparam logic [1:0] RDST_RT  = 2'd0;
    localparam logic [1:0] RDST_RD  = 2'd1;
    localparam logic [1:0] RDST_R31 = 2'd2;

    localparam logic [1:0] WDST_ALU_MEM = 2'd0;
    localparam logic [1:0] WDST_PC      = 2'd1;
    localparam logic [1:0] WDST_HI      = 2'd2;
    localparam logic [1:0] WDST_LO      = 2'd3;

    localparam logic [1:0] PCSRC_ALU  = 2'd0;
    localparam logic [1:0] PCSRC_JUMP = 2'd1;
    localparam logic [1:0] PCSRC_REGA = 2'd2;

    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // Instruction dispatch out of DECODE; anything unrecognised traps.
    function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_e nxt;
        nxt = S_ILLEGAL;
        case (op)
            OP_LW, OP_SW:    nxt = S_MEM_ADDR;
            OP_BEQ:          nxt = S_BRANCH;
            OP_ADDI, OP_SLTI: nxt = S_I_EXEC;
            OP_J, OP_JAL:    nxt = S_JUMP;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_R_EXEC;
                    FN_MULT:          nxt = S_MULT;
                    FN_MFHI, FN_MFLO: nxt = S_MFHL;
                    FN_JR:            nxt = S_JR;
                    default:          nxt = S_ILLEGAL;
                endcase
            end
            default: nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// Maps the instruction's opcode/func fields to the ALU operation code used by
// the execute and write-back states.
module alu_op_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_MULT: alu_op = ALU_MULT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_SLTI: alu_op = ALU_SLT;
            OP_BEQ:  alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle MIPS datapath, with a bounded
// memory-wait counter and a sticky fault flag for traps and timeouts.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       PC_write_cond,
    output logic       IorD,
    output logic       IR_write,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       MemtoReg,
    output logic       Reg_Write,
    output logic       ld,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] regDst,
    output logic [1:0] writeDst,
    output logic [1:0] PC_src,
    output logic [3:0] ALUOperation,
    output logic       err,
    output logic [3:0] state_o
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
    logic          timeout;
    logic [3:0]    alu_op_dec;

    // Zero gates PC_write_cond inside the datapath, not here.
    logic unused_zero;
    assign unused_zero = Zero;

    alu_op_decoder u_alu_op_decoder (
        .opcode (opcode),
        .func   (func),
        .alu_op (alu_op_dec)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        err_d      = err_q;
        timeout    = 1'b0;

        // The timeout fires on the last permitted idle cycle; a mem_ready in
        // that same cycle still completes the access.
        if (is_wait_state(state_q) && !mem_ready) begin
            if (wait_cnt_q == CW'(WAIT_LIMIT - 1)) begin
                timeout = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(opcode, func);
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_ILLEGAL: begin
                err_d   = 1'b1;
                state_d = S_FETCH;
            end
            default:    state_d = S_FETCH;
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            state_d = S_FETCH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Output decode. Strobes are qualified by the reset pin itself so they
    // drop the moment reset asserts, even in FETCH.
    always_comb begin
        PC_write      = 1'b0;
        PC_write_cond = 1'b0;
        IorD          = 1'b0;
        IR_write      = 1'b0;
        Mem_Read      = 1'b0;
        Mem_Write     = 1'b0;
        MemtoReg      = 1'b0;
        Reg_Write     = 1'b0;
        ld            = 1'b0;
        ALUsrcA       = 1'b0;
        ALUsrcB       = SRCB_REG;
        regDst        = RDST_RT;
        writeDst      = WDST_ALU_MEM;
        PC_src        = PCSRC_ALU;
        ALUOperation  = ALU_AND;

        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    Mem_Read     = 1'b1;
                    ALUsrcB      = SRCB_FOUR;
                    ALUOperation = ALU_ADD;
                    IR_write     = mem_ready;
                    PC_write     = mem_ready;
                end
                S_DECODE: begin
                    ALUsrcB      = SRCB_SEXT_SH;
                    ALUOperation = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    ALUsrcA      = 1'b1;
                    ALUsrcB      = SRCB_SEXT;
                    ALUOperation = ALU_ADD;
                end
                S_MEM_RD: begin
                    Mem_Read = 1'b1;
                    IorD     = 1'b1;
                end
                S_MEM_WB: begin
                    Reg_Write = 1'b1;
                    MemtoReg  = 1'b1;
                end
                S_MEM_WR: begin
                    Mem_Write = 1'b1;
                    IorD      = 1'b1;
                end
                S_R_EXEC: begin
                    ALUsrcA      = 1'b1;
                    ALUOperation = alu_op_dec;
                end
                S_R_WB: begin
                    ALUsrcA      = 1'b1;
                    ALUOperation = alu_op_dec;
                    Reg_Write    = 1'b1;
                    regDst       = RDST_RD;
                end
                S_I_EXEC: begin
                    ALUsrcA      = 1'b1;
                    ALUsrcB      = SRCB_SEXT;
                    ALUOperation = alu_op_dec;
                end
                S_I_WB: begin
                    ALUsrcA      = 1'b1;
                    ALUsrcB      = SRCB_SEXT;
                    ALUOperation = alu_op_dec;
                    Reg_Write    = 1'b1;
                end
                S_BRANCH: begin
                    ALUsrcA       = 1'b1;
                    ALUOperation  = ALU_SUB;
                    PC_write_cond = 1'b1;
                end
                S_JUMP: begin
                    PC_write = 1'b1;
                    PC_src   = PCSRC_JUMP;
                    if (opcode == OP_JAL) begin
                        Reg_Write = 1'b1;
                        regDst    = RDST_R31;
                        writeDst  = WDST_PC;
                    end
                end
                S_JR: begin
                    PC_write = 1'b1;
                    PC_src   = PCSRC_REGA;
                end
                S_MULT: begin
                    ALUsrcA      = 1'b1;
                    ALUOperation = ALU_MULT;
                    ld           = 1'b1;
                end
                S_MFHL: begin
                    Reg_Write = 1'b1;
                    regDst    = RDST_RD;
                    writeDst  = (func == FN_MFLO) ? WDST_LO : WDST_HI;
                end
                default: ;
            endcase
        end
    end

    assign err     = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected traces built from the
// instruction-level rules, a directed table, hand-written reset cases, and
// randomized instruction streams.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int WAIT_LIMIT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, func;
    logic       Zero, mem_ready;
    logic       PC_write, PC_write_cond, IorD, IR_write, Mem_Read, Mem_Write;
    logic       MemtoReg, Reg_Write, ld, ALUsrcA, err;
    logic [1:0] ALUsrcB, regDst, writeDst, PC_src;
    logic [3:0] ALUOperation, state_o;

    int checks = 0;
    int errors = 0;
    logic m_err = 1'b0;

    multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .Zero(Zero),
        .mem_ready(mem_ready), .PC_write(PC_write), .PC_write_cond(PC_write_cond),
        .IorD(IorD), .IR_write(IR_write), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .MemtoReg(MemtoReg), .Reg_Write(Reg_Write), .ld(ld), .ALUsrcA(ALUsrcA),
        .ALUsrcB(ALUsrcB), .regDst(regDst), .writeDst(writeDst), .PC_src(PC_src),
        .ALUOperation(ALUOperation), .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
        logic       memtoreg, reg_write, ld, alusrca;
        logic [1:0] alusrcb, regdst, writedst, pc_src;
        logic [3:0] aluop;
        logic       err;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        logic rdy;
        obs_t exp;
    } step_t;

    typedef struct {
        string      name;
        logic [5:0] op, fn;
        int         fw, mw;
        int         n_regw, n_pcw;
        logic       err_after;
        logic       rst_before;
    } vec_t;

    step_t trace[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample_dut();
        obs_t o;
        o.pc_write = PC_write; o.pc_write_cond = PC_write_cond; o.iord = IorD;
        o.ir_write = IR_write; o.mem_read = Mem_Read; o.mem_write = Mem_Write;
        o.memtoreg = MemtoReg; o.reg_write = Reg_Write; o.ld = ld; o.alusrca = ALUsrcA;
        o.alusrcb = ALUsrcB; o.regdst = regDst; o.writedst = writeDst; o.pc_src = PC_src;
        o.aluop = ALUOperation; o.err = err; o.state = state_o;
        return o;
    endfunction

    function automatic obs_t base(input state_e s);
        obs_t o = '0;
        o.state = s;
        o.err   = m_err;
        return o;
    endfunction

    function automatic void push(input logic rdy, input obs_t o);
        step_t s;
        s.rdy = rdy;
        s.exp = o;
        trace.push_back(s);
    endfunction

    function automatic logic any_rdy();
        return 1'($urandom_range(0, 1));
    endfunction

    // Arithmetic ALU code from the instruction's meaning.
    function automatic logic [3:0] spec_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_SLTI) return 4'd7;
        if (op == OP_RTYPE) begin
            if (fn == FN_SUB) return 4'd6;
            if (fn == FN_AND) return 4'd0;
            if (fn == FN_OR)  return 4'd1;
            if (fn == FN_SLT) return 4'd7;
        end
        return 4'd2;
    endfunction

    // Idle phase of a memory state: w low cycles, capped at the limit, then
    // either the completing cycle or a timeout. Returns 1 on timeout.
    function automatic logic mem_phase(input obs_t o, input int w);
        int n = (w >= WAIT_LIMIT) ? WAIT_LIMIT : w;
        for (int i = 0; i < n; i++) push(1'b0, o);
        if (w >= WAIT_LIMIT) begin
            m_err = 1'b1;
            return 1'b1;
        end
        push(1'b1, o);
        return 1'b0;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction from FETCH back to FETCH.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        obs_t o;
        logic to;
        logic is_r;
        trace.delete();
        o = base(S_FETCH);
        o.mem_read = 1'b1; o.alusrcb = 2'd1; o.aluop = 4'd2;
        if (fw >= WAIT_LIMIT) begin
            to = mem_phase(o, fw);
            return;
        end
        for (int i = 0; i < fw; i++) push(1'b0, o);
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(1'b1, o);
        o = base(S_DECODE); o.alusrcb = 2'd3; o.aluop = 4'd2;
        push(any_rdy(), o);
        is_r = (op == OP_RTYPE);
        if (op == OP_LW || op == OP_SW) begin
            o = base(S_MEM_ADDR); o.alusrca = 1'b1; o.alusrcb = 2'd2; o.aluop = 4'd2;
            push(any_rdy(), o);
            if (op == OP_LW) begin
                o = base(S_MEM_RD); o.mem_read = 1'b1; o.iord = 1'b1;
                if (!mem_phase(o, mw)) begin
                    o = base(S_MEM_WB); o.reg_write = 1'b1; o.memtoreg = 1'b1;
                    push(any_rdy(), o);
                end
            end else begin
                o = base(S_MEM_WR); o.mem_write = 1'b1; o.iord = 1'b1;
                to = mem_phase(o, mw);
            end
        end else if (is_r && (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT)) begin
            o = base(S_R_EXEC); o.alusrca = 1'b1; o.aluop = spec_alu(op, fn);
            push(any_rdy(), o);
            o.state = S_R_WB; o.reg_write = 1'b1; o.regdst = 2'd1;
            push(any_rdy(), o);
        end else if (is_r && fn == FN_MULT) begin
            o = base(S_MULT); o.alusrca = 1'b1; o.aluop = 4'd8; o.ld = 1'b1;
            push(any_rdy(), o);
        end else if (is_r && (fn == FN_MFHI || fn == FN_MFLO)) begin
            o = base(S_MFHL); o.reg_write = 1'b1; o.regdst = 2'd1;
            o.writedst = (fn == FN_MFHI) ? 2'd2 : 2'd3;
            push(any_rdy(), o);
        end else if (is_r && fn == FN_JR) begin
            o = base(S_JR); o.pc_write = 1'b1; o.pc_src = 2'd2;
            push(any_rdy(), o);
        end else if (op == OP_BEQ) begin
            o = base(S_BRANCH); o.alusrca = 1'b1; o.aluop = 4'd6; o.pc_write_cond = 1'b1;
            push(any_rdy(), o);
        end else if (op == OP_ADDI || op == OP_SLTI) begin
            o = base(S_I_EXEC); o.alusrca = 1'b1; o.alusrcb = 2'd2; o.aluop = spec_alu(op, fn);
            push(any_rdy(), o);
            o.state = S_I_WB; o.reg_write = 1'b1;
            push(any_rdy(), o);
        end else if (op == OP_J || op == OP_JAL) begin
            o = base(S_JUMP); o.pc_write = 1'b1; o.pc_src = 2'd1;
            if (op == OP_JAL) begin
                o.reg_write = 1'b1; o.regdst = 2'd2; o.writedst = 2'd1;
            end
            push(any_rdy(), o);
        end else begin
            push(any_rdy(), base(S_ILLEGAL));
            m_err = 1'b1;
        end
    endfunction

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, output int regw, output int pcw);
        obs_t act;
        opcode = op;
        func   = fn;
        build(op, fn, fw, mw);
        regw = 0;
        pcw  = 0;
        for (int i = 0; i < trace.size(); i++) begin
            mem_ready = trace[i].rdy;
            Zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            act = sample_dut();
            check($sformatf("%s cycle %0d", name, i), 64'(act), 64'(trace[i].exp));
            if (act.reg_write) regw++;
            if (act.pc_write) pcw++;
            @(posedge clk);
            #1;
        end
    endtask

    // Entered at posedge+1; releases reset at posedge+1 so the next edge is
    // the first FETCH cycle.
    task automatic do_reset();
        mem_ready = 1'b0;
        reset = 1'b0;
        #2;
        check("outputs in reset", 64'(sample_dut()), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_err = 1'b0;
    endtask

    vec_t vt[$];

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                                input int fw, input int mw, input int nr, input int np,
                                input logic e, input logic rb);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.fw = fw; v.mw = mw;
        v.n_regw = nr; v.n_pcw = np; v.err_after = e; v.rst_before = rb;
        return v;
    endfunction

    initial begin
        int rw, pw;
        logic seen;
        logic [5:0] rop, rfn;
        int pick, fw, mw;

        reset = 1'b0; mem_ready = 1'b0; opcode = '0; func = '0; Zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        vt.push_back(mk("lw",        OP_LW,    6'd0,    2,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("sw",        OP_SW,    6'd0,    0,  3, 0, 1, 1'b0, 1'b0));
        vt.push_back(mk("add",       OP_RTYPE, FN_ADD,  1,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("sub",       OP_RTYPE, FN_SUB,  0,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("and",       OP_RTYPE, FN_AND,  0,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("or",        OP_RTYPE, FN_OR,   2,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("slt",       OP_RTYPE, FN_SLT,  0,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("addi",      OP_ADDI,  6'd5,    0,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("slti",      OP_SLTI,  6'd9,    1,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("beq",       OP_BEQ,   6'd0,    0,  0, 0, 1, 1'b0, 1'b0));
        vt.push_back(mk("j",         OP_J,     6'd0,    0,  0, 0, 2, 1'b0, 1'b0));
        vt.push_back(mk("jal",       OP_JAL,   6'd0,    0,  0, 1, 2, 1'b0, 1'b0));
        vt.push_back(mk("jr",        OP_RTYPE, FN_JR,   0,  0, 0, 2, 1'b0, 1'b0));
        vt.push_back(mk("mult",      OP_RTYPE, FN_MULT, 0,  0, 0, 1, 1'b0, 1'b0));
        vt.push_back(mk("mfhi",      OP_RTYPE, FN_MFHI, 0,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("mflo",      OP_RTYPE, FN_MFLO, 0,  0, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("lw_late",   OP_LW,    6'd0,    0, 14, 1, 1, 1'b0, 1'b0));
        vt.push_back(mk("sw_tmo",    OP_SW,    6'd0,    0, 15, 0, 1, 1'b1, 1'b0));
        vt.push_back(mk("add_sticky", OP_RTYPE, FN_ADD, 0,  0, 1, 1, 1'b1, 1'b0));
        vt.push_back(mk("ill_op",    6'b111111, 6'd0,   0,  0, 0, 1, 1'b1, 1'b1));
        vt.push_back(mk("ill_fn",    OP_RTYPE, 6'b111111, 1, 0, 0, 1, 1'b1, 1'b0));
        vt.push_back(mk("fetch_tmo", OP_LW,    6'd0,   15,  0, 0, 0, 1'b1, 1'b1));
        vt.push_back(mk("lw_tmo",    OP_LW,    6'd0,    3, 15, 0, 1, 1'b1, 1'b1));

        foreach (vt[i]) begin
            if (vt[i].rst_before) do_reset();
            run_instr(vt[i].name, vt[i].op, vt[i].fn, vt[i].fw, vt[i].mw, rw, pw);
            check({vt[i].name, " reg_write pulses"}, 64'(rw), 64'(vt[i].n_regw));
            check({vt[i].name, " pc_write pulses"}, 64'(pw), 64'(vt[i].n_pcw));
            check({vt[i].name, " err after"}, 64'(err), 64'(vt[i].err_after));
        end

        // Reset pulled low while a load is in its write-back cycle.
        do_reset();
        opcode = OP_LW; func = '0; mem_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (state_o == 4'(S_MEM_WB)) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached MEM_WB", 64'(seen), 64'(1));
        check("reg_write in MEM_WB", 64'(Reg_Write), 64'(seen));
        #2;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("async reset outputs", 64'(sample_dut()), 64'(0));
        @(negedge clk);
        #1;
        reset = 1'b1;
        rw = 0;
        repeat (4) begin
            @(negedge clk);
            if (Reg_Write) rw++;
        end
        check("reg_write after reset release", 64'(rw), 64'(0));
        check("state after reset release", 64'(state_o), 64'(S_FETCH));
        @(posedge clk);
        #1;
        do_reset();

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 15);
            rop = OP_RTYPE;
            rfn = 6'($urandom_range(0, 63));
            case (pick)
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rfn = FN_ADD;
                3: rfn = FN_SUB;
                4: rfn = FN_AND;
                5: rfn = FN_OR;
                6: rfn = FN_SLT;
                7: rfn = FN_MULT;
                8: rfn = FN_MFHI;
                9: rfn = FN_MFLO;
                10: rfn = FN_JR;
                11: rop = OP_BEQ;
                12: rop = ($urandom_range(0, 1) == 1) ? OP_ADDI : OP_SLTI;
                13: rop = ($urandom_range(0, 1) == 1) ? OP_J : OP_JAL;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            fw = ($urandom_range(0, 9) == 0) ? WAIT_LIMIT : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? WAIT_LIMIT : $urandom_range(0, 4);
            run_instr($sformatf("rand%0d", n), rop, rfn, fw, mw, rw, pw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
